// File: rtl/prol16_mem_pkg.sv
// Memory responder types: FSM states, decoded bus access kinds and counter helpers.
package prol16_mem_pkg;

    localparam int CNT_WIDTH = 16;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_ERR   = 2'd3
    } access_t;

    // Strobes are active-low; oe_n and we_n together is a bus conflict, not an access.
    function automatic access_t decode_access(input logic ce_n, input logic oe_n, input logic we_n);
        access_t acc;
        acc = ACC_NONE;
        if (!ce_n) begin
            if (!oe_n && !we_n) acc = ACC_ERR;
            else if (!oe_n)     acc = ACC_READ;
            else if (!we_n)     acc = ACC_WRITE;
        end
        return acc;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/prol16_types_pkg.sv
// Shared PROL16 CPU types: machine word width used across CPU and memory-side blocks.
package prol16_types_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/prol16_mem_rd_pipe.sv
// Read-data delay line of gDepth stages; each stage only reloads on valid, so the last
// stage doubles as the bus keeper for mem_data_i.
module prol16_mem_rd_pipe #(
    parameter int gDataWidth = 16,
    parameter int gDepth     = 1
) (
    input  logic                  clk,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [gDataWidth-1:0] i_data,
    output logic [gDataWidth-1:0] o_data
);

    logic [gDepth-1:0]     r_valid;
    logic [gDataWidth-1:0] r_data [gDepth];

    // NOTE: state registers use non-blocking assignments so every stage samples the
    // pre-edge value of its predecessor, regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_valid <= '0;
            for (int i = 0; i < gDepth; i++) r_data[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) r_data[0] <= i_data;
            for (int i = 1; i < gDepth; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_data = r_data[gDepth-1];

endmodule

// File: rtl/prol16_mem_responder.sv
// Memory-side responder for the PROL16 bus: internal word RAM, pipelined reads,
// backdoor preload, halt FSM, sticky status flags and saturating access counters.
module prol16_mem_responder
    import prol16_types_pkg::*;
    import prol16_mem_pkg::*;
#(
    parameter int gDataWidth    = DATA_WIDTH,
    parameter int gMemDepthLog2 = 10,
    parameter int gReadLatency  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [gDataWidth-1:0]    mem_addr_o,
    input  logic [gDataWidth-1:0]    mem_data_o,
    input  logic                     mem_ce_no,
    input  logic                     mem_oe_no,
    input  logic                     mem_we_no,
    input  logic                     illegal_inst_o,
    input  logic                     cpu_halt_o,
    output logic [gDataWidth-1:0]    mem_data_i,
    input  logic                     load_en_i,
    input  logic [gMemDepthLog2-1:0] load_addr_i,
    input  logic [gDataWidth-1:0]    load_data_i,
    output logic                     halted_o,
    output logic                     illegal_o,
    output logic                     bus_err_o,
    output logic [CNT_WIDTH-1:0]     rd_count_o,
    output logic [CNT_WIDTH-1:0]     wr_count_o
);

    localparam int MEM_WORDS = 2 ** gMemDepthLog2;

    state_t                   r_state;
    state_t                   w_state_next;
    access_t                  w_access;
    logic                     w_cpu_rd;
    logic                     w_cpu_wr;
    logic                     w_bus_err;
    logic [gMemDepthLog2-1:0] w_index;
    logic [gDataWidth-1:0]    w_rd_word;
    logic [gDataWidth-1:0]    r_mem [MEM_WORDS];
    logic                     r_illegal;
    logic                     r_bus_err;
    cnt_t                     r_rd_count;
    cnt_t                     r_wr_count;
    logic                     w_unused_addr_hi;

    // Upper address bits are deliberately dropped so the address space wraps at the RAM depth.
    assign w_index          = mem_addr_o[gMemDepthLog2-1:0];
    assign w_unused_addr_hi = ^mem_addr_o[gDataWidth-1:gMemDepthLog2];
    assign w_access         = decode_access(mem_ce_no, mem_oe_no, mem_we_no);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cpu_rd     = 1'b0;
        w_cpu_wr     = 1'b0;
        w_bus_err    = 1'b0;
        case (r_state)
            RUN: begin
                w_cpu_rd  = !rst && (w_access == ACC_READ);
                w_cpu_wr  = !rst && (w_access == ACC_WRITE) && !load_en_i;
                w_bus_err = !rst && (w_access == ACC_ERR);
                if (cpu_halt_o) w_state_next = HALTED;
            end
            HALTED: w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // NOTE: the RAM array has no reset; its contents survive rst and only writes change it.
    always_ff @(posedge clk) begin
        if (load_en_i)     r_mem[load_addr_i] <= load_data_i;
        else if (w_cpu_wr) r_mem[w_index]     <= mem_data_o;
    end

    // Asynchronous read taken before the edge: a same-cycle write is seen only by the next read.
    assign w_rd_word = r_mem[w_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (illegal_inst_o) r_illegal  <= 1'b1;
            if (w_bus_err)      r_bus_err  <= 1'b1;
            if (w_cpu_rd)       r_rd_count <= sat_inc(r_rd_count);
            if (w_cpu_wr)       r_wr_count <= sat_inc(r_wr_count);
        end
    end

    prol16_mem_rd_pipe #(
        .gDataWidth (gDataWidth),
        .gDepth     (gReadLatency)
    ) u_rd_pipe (
        .clk     (clk),
        .i_flush (rst),
        .i_valid (w_cpu_rd),
        .i_data  (w_rd_word),
        .o_data  (mem_data_i)
    );

    assign halted_o   = (r_state == HALTED);
    assign illegal_o  = r_illegal;
    assign bus_err_o  = r_bus_err;
    assign rd_count_o = r_rd_count;
    assign wr_count_o = r_wr_count;

endmodule
